// File: rtl/data_sram_responder_pkg.sv
// Shared constants, read-source select type and byte-lane merge helper for the data_sram responder.
package data_sram_responder_pkg;

    localparam int unsigned DSRAM_ADDR_W = 14;

    localparam logic [15:0] MMIO_LED    = 16'h0000;
    localparam logic [15:0] MMIO_SW     = 16'h0004;
    localparam logic [15:0] MMIO_TIMER  = 16'h0008;
    localparam logic [15:0] MMIO_CMP    = 16'h000C;
    localparam logic [15:0] MMIO_STATUS = 16'h0010;

    // Source that currently drives rdata; NONE after reset so rdata reads zero.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_RAM  = 2'd1,
        RD_MMIO = 2'd2
    } rd_sel_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram request/response bundle between the core (master) and the responder (slave).
interface data_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_dsram_bank.sv
// Single-port word RAM with byte-lane write enables and a one-cycle registered read port.
module dsram_bank #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // A request is either a read or a write, so read-during-write ordering never matters here.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// data_sram target: RAM bank plus LED/switch/timer MMIO window; read data appears one cycle after
// the request edge and holds until the next accepted read.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = DSRAM_ADDR_W,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
    parameter int unsigned SW_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_sram_responder_if.slave bus,
    output logic [15:0]          led_o,
    input  logic [SW_W-1:0]      switch_i,
    output logic                 timer_irq_o
);
    logic            is_mmio;
    logic            req_rd;
    logic            req_wr;
    logic            mmio_wr;
    logic            ram_en;
    logic            irq_clr;
    logic [15:0]     off;
    logic [31:0]     ram_rdata;
    logic [31:0]     mmio_rd_val;
    logic            unused_addr_lsb;

    logic [15:0]     led_q, led_d;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    logic [31:0]     timer_q, timer_d;
    logic [31:0]     cmp_q, cmp_d;
    logic [31:0]     mmio_rdata_q, mmio_rdata_d;
    logic            irq_q, irq_d;
    rd_sel_e         rd_sel_q, rd_sel_d;

    assign is_mmio         = (bus.addr[31:16] == MMIO_BASE[31:16]);
    assign off             = {bus.addr[15:2], 2'b00};
    assign unused_addr_lsb = ^bus.addr[1:0];
    assign req_rd          = bus.en && (bus.wen == 4'b0000);
    assign req_wr          = bus.en && (bus.wen != 4'b0000);
    assign mmio_wr         = req_wr && is_mmio;
    // The RAM has no reset of its own; keep it untouched while the block is held in reset.
    assign ram_en          = bus.en && !is_mmio && rst_n;

    dsram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (bus.wen),
        .addr_i  (bus.addr[ADDR_W+1:2]),
        .wdata_i (bus.wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        mmio_rd_val = '0;
        case (off)
            MMIO_LED:    mmio_rd_val = {16'h0000, led_q};
            MMIO_SW:     mmio_rd_val = 32'(sw_sync_q);
            MMIO_TIMER:  mmio_rd_val = timer_q;
            MMIO_CMP:    mmio_rd_val = cmp_q;
            MMIO_STATUS: mmio_rd_val = {31'd0, irq_q};
            default:     mmio_rd_val = '0;
        endcase
    end

    always_comb begin
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        cmp_d        = cmp_q;
        irq_clr      = 1'b0;
        mmio_rdata_d = mmio_rdata_q;
        rd_sel_d     = rd_sel_q;

        if (mmio_wr) begin
            case (off)
                MMIO_LED: begin
                    if (bus.wen[0]) led_d[7:0]  = bus.wdata[7:0];
                    if (bus.wen[1]) led_d[15:8] = bus.wdata[15:8];
                end
                MMIO_TIMER:  timer_d = lane_merge(timer_q, bus.wdata, bus.wen);
                MMIO_CMP:    cmp_d   = lane_merge(cmp_q, bus.wdata, bus.wen);
                MMIO_STATUS: irq_clr = bus.wen[0] && bus.wdata[0];
                default:     ;
            endcase
        end

        // Match is taken on the value the timer holds after this edge; a set beats a clear.
        irq_d = (timer_d == cmp_q) || (irq_q && !irq_clr);

        if (req_rd) begin
            rd_sel_d = is_mmio ? RD_MMIO : RD_RAM;
            if (is_mmio) begin
                mmio_rdata_d = mmio_rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q        <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            timer_q      <= '0;
            cmp_q        <= 32'hFFFF_FFFF;
            irq_q        <= 1'b0;
            mmio_rdata_q <= '0;
            rd_sel_q     <= RD_NONE;
        end else begin
            led_q        <= led_d;
            sw_meta_q    <= switch_i;
            sw_sync_q    <= sw_meta_q;
            timer_q      <= timer_d;
            cmp_q        <= cmp_d;
            irq_q        <= irq_d;
            mmio_rdata_q <= mmio_rdata_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (rd_sel_q)
            RD_RAM:  bus.rdata = ram_rdata;
            RD_MMIO: bus.rdata = mmio_rdata_q;
            default: bus.rdata = '0;
        endcase
    end

    assign led_o       = led_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table, hand-written timer/IRQ/reset sequences,
// then randomized traffic against a behavioural model of the memory map.
module tb_data_sram_responder;

    localparam logic [15:0] MMIO_HI = 16'hBFAF;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic [15:0] led;
    logic        irq;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];

    // behavioural model state
    bit          use_model = 1'b0;
    logic [31:0] m_ram [int];
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    logic        m_irq;
    logic [31:0] m_rdata;
    logic [7:0]  m_sw_d1;
    logic [7:0]  m_sw_d2;

    always #5 clk = ~clk;

    data_sram_responder_if bus ();

    data_sram_responder #(
        .ADDR_W    (14),
        .MMIO_BASE (32'hBFAF_0000),
        .SW_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .led_o       (led),
        .switch_i    (sw),
        .timer_irq_o (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic model_step(input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wdata);
        logic        mm;
        logic        clr;
        int          idx;
        logic [15:0] o;
        logic [31:0] t_next;
        logic [31:0] c_next;
        logic [31:0] tmp;
        mm     = (addr[31:16] == MMIO_HI);
        idx    = int'((addr >> 2) % 32'd16384);
        o      = addr[15:0] & 16'hFFFC;
        t_next = m_timer + 32'd1;
        c_next = m_cmp;
        clr    = 1'b0;
        if (en && wen == 4'd0) begin
            if (!mm) begin
                m_rdata = m_ram[idx];
            end else begin
                case (o)
                    16'h00:  m_rdata = {16'h0, m_led};
                    16'h04:  m_rdata = {24'h0, m_sw_d2};
                    16'h08:  m_rdata = m_timer;
                    16'h0C:  m_rdata = m_cmp;
                    16'h10:  m_rdata = {31'h0, m_irq};
                    default: m_rdata = 32'h0;
                endcase
            end
        end else if (en) begin
            if (!mm) begin
                tmp = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                m_ram[idx] = bmerge(tmp, wdata, wen);
            end else begin
                case (o)
                    16'h00: begin
                        tmp   = bmerge({16'h0, m_led}, wdata, {2'b00, wen[1:0]});
                        m_led = tmp[15:0];
                    end
                    16'h08:  t_next = bmerge(m_timer, wdata, wen);
                    16'h0C:  c_next = bmerge(m_cmp, wdata, wen);
                    16'h10:  clr = wen[0] & wdata[0];
                    default: ;
                endcase
            end
        end
        m_irq   = (t_next == m_cmp) || (m_irq && !clr);
        m_timer = t_next;
        m_cmp   = c_next;
        m_sw_d2 = m_sw_d1;
        m_sw_d1 = sw;
    endtask

    task automatic cyc(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        if (use_model) model_step(en, wen, addr, wdata);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        cyc(1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        cyc(1'b1, wen, addr, wdata);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic add(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic [15:0] el);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_led = el;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  we;
        logic [15:0] up;
        logic [15:0] offs [6];

        bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
        offs[0] = 16'h00; offs[1] = 16'h04; offs[2] = 16'h08;
        offs[3] = 16'h0C; offs[4] = 16'h10; offs[5] = 16'h18;

        // directed table: write/merge/read, hold, alias, LED lanes, unmapped offsets
        add(1, 4'hF, 32'h0000_0100, 32'h1122_3344, 32'h0,         16'h0);
        add(1, 4'h2, 32'h0000_0100, 32'h0000_AA00, 32'h0,         16'h0);
        add(1, 4'h0, 32'h0000_0100, 32'h0,         32'h1122_AA44, 16'h0);
        add(0, 4'h0, 32'h0000_0100, 32'h0,         32'h1122_AA44, 16'h0);
        add(0, 4'hF, 32'h0000_0100, 32'h0,         32'h1122_AA44, 16'h0);
        add(0, 4'h0, 32'h0000_0000, 32'h0,         32'h1122_AA44, 16'h0);
        add(1, 4'hF, 32'h0000_0200, 32'h5555_5555, 32'h1122_AA44, 16'h0);
        add(1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1122_AA44, 16'h0);
        add(1, 4'h0, 32'h0001_0010, 32'h0,         32'hDEAD_BEEF, 16'h0);
        add(1, 4'hF, 32'hBFAF_0000, 32'hFFFF_5A5A, 32'hDEAD_BEEF, 16'h5A5A);
        add(1, 4'h0, 32'hBFAF_0000, 32'h0,         32'h0000_5A5A, 16'h5A5A);
        add(1, 4'hC, 32'hBFAF_0000, 32'h1234_0000, 32'h0000_5A5A, 16'h5A5A);
        add(1, 4'h1, 32'hBFAF_0000, 32'h0000_00C3, 32'h0000_5A5A, 16'h5AC3);
        add(1, 4'h0, 32'hBFAF_0020, 32'h0,         32'h0,         16'h5AC3);
        add(1, 4'h0, 32'h0000_0103, 32'h0,         32'h1122_AA44, 16'h5AC3);
        add(1, 4'h0, 32'h0000_0200, 32'h0,         32'h5555_5555, 16'h5AC3);
        add(1, 4'h0, 32'hBFAF_0010, 32'h0,         32'h0,         16'h5AC3);
        add(1, 4'h0, 32'hBFAF_0001, 32'h0,         32'h0000_5AC3, 16'h5AC3);
        add(1, 4'h0, 32'hFFFF_0100, 32'h0,         32'h1122_AA44, 16'h5AC3);

        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
            check($sformatf("tbl_rdata[%0d]", i), bus.rdata, tbl[i].exp_rdata);
            check($sformatf("tbl_led[%0d]", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
        end

        // switch synchroniser; writes to SWITCH ignored
        sw = 8'h3C;
        idle(); idle();
        rd(32'hBFAF_0004);
        check("switch_read", bus.rdata, 32'h0000_003C);
        wr(32'hBFAF_0004, 4'hF, 32'h0);
        rd(32'hBFAF_0004);
        check("switch_ro", bus.rdata, 32'h0000_003C);

        // timer reaches COMPARE, irq sticky, write-1-clear
        wr(32'hBFAF_0010, 4'h1, 32'h1);
        wr(32'hBFAF_0008, 4'hF, 32'd10);
        wr(32'hBFAF_000C, 4'hF, 32'd20);
        repeat (8) idle();
        check("irq_before_match", {31'h0, irq}, 32'h0);
        idle();
        check("irq_at_match", {31'h0, irq}, 32'h1);
        rd(32'hBFAF_0008);
        check("timer_at_match", bus.rdata, 32'd20);
        repeat (3) idle();
        check("irq_sticky", {31'h0, irq}, 32'h1);
        wr(32'hBFAF_0010, 4'h1, 32'h1);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd(32'hBFAF_0010);
        check("status_cleared", bus.rdata, 32'h0);

        // clear on the same edge as the match: set wins
        wr(32'hBFAF_0008, 4'hF, 32'd10);
        repeat (9) idle();
        check("irq_before_match2", {31'h0, irq}, 32'h0);
        wr(32'hBFAF_0010, 4'hF, 32'hFFFF_FFFF);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        rd(32'hBFAF_0010);
        check("status_set", bus.rdata, 32'h1);

        // load without increment, then wrap
        wr(32'hBFAF_0008, 4'hF, 32'hFFFF_FFFF);
        rd(32'hBFAF_0008);
        check("timer_loaded", bus.rdata, 32'hFFFF_FFFF);
        rd(32'hBFAF_0008);
        check("timer_wrap", bus.rdata, 32'h0);
        rd(32'hBFAF_000C);
        check("cmp_read", bus.rdata, 32'd20);

        // reset mid-stream
        rd(32'h0000_0100);
        check("pre_reset_read", bus.rdata, 32'h1122_AA44);
        rst_n = 1'b0;
        #1;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        bus.en = 1'b1; bus.wen = 4'hF; bus.addr = 32'h0000_0100; bus.wdata = 32'h0;
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.wen = 4'h0;
        rst_n = 1'b1;
        rd(32'hBFAF_0008);
        check("timer_after_reset", bus.rdata, 32'h0);
        rd(32'hBFAF_000C);
        check("cmp_after_reset", bus.rdata, 32'hFFFF_FFFF);
        rd(32'h0000_0100);
        check("ram_kept", bus.rdata, 32'h1122_AA44);
        rd(32'hBFAF_0000);
        check("led_after_reset", bus.rdata, 32'h0);

        // randomized traffic against the model
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        m_ram.delete();
        m_led = 16'h0; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_irq = 1'b0;
        m_rdata = 32'h0; m_sw_d1 = 8'h0; m_sw_d2 = 8'h0;
        use_model = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr({16'h0000, 14'(32 + i), 2'b00}, 4'hF, $urandom);
        end
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 5) == 0) sw = 8'($urandom);
            r  = $urandom_range(0, 9);
            we = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            wd = $urandom;
            if (r <= 4) begin
                up = 16'($urandom);
                if (up == MMIO_HI) up = 16'h0000;
                a = {up, 14'(32 + $urandom_range(0, 7)), 2'($urandom)};
                cyc(1'b1, we, a, wd);
            end else if (r <= 8) begin
                a = {MMIO_HI, offs[$urandom_range(0, 5)] | 16'($urandom_range(0, 3))};
                if (a[15:2] == 14'h3 && $urandom_range(0, 1) == 1) begin
                    we = 4'hF;
                    wd = m_timer + 32'($urandom_range(1, 20));
                end
                cyc(1'b1, we, a, wd);
            end else begin
                cyc(1'b0, we, 32'($urandom), wd);
            end
            check($sformatf("rand_rdata[%0d]", n), bus.rdata, m_rdata);
            check($sformatf("rand_led[%0d]", n), {16'h0, led}, {16'h0, m_led});
            check($sformatf("rand_irq[%0d]", n), {31'h0, irq}, {31'h0, m_irq});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
